// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared sizing constants and types for the endpoint data buffer
package db_pkg;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH) + 1;

    typedef logic [PTR_W-1:0]  db_ptr_t;
    typedef logic [DATA_W-1:0] db_byte_t;

endpackage

// File: rtl/db_occ_counter.sv
// rtl/db_occ_counter.sv - up/down occupancy counter, sync clear, saturating at 0 and DEPTH
module db_occ_counter
    import db_pkg::*;
(
    input  logic    clk,
    input  logic    n_rst,
    input  logic    clr_i,
    input  logic    inc_i,
    input  logic    dec_i,
    output db_ptr_t occ_o
);

    localparam db_ptr_t OCC_MAX = PTR_W'(DEPTH);

    db_ptr_t occ_q;
    db_ptr_t occ_d;
    logic    inc_ok;
    logic    dec_ok;

    assign inc_ok = inc_i && (occ_q != OCC_MAX);
    assign dec_ok = dec_i && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (clr_i) begin
            occ_d = '0;
        end else begin
            // Simultaneous increment and decrement cancel out.
            case ({inc_ok, dec_ok})
                2'b10:   occ_d = occ_q + PTR_W'(1);
                2'b01:   occ_d = occ_q - PTR_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/db_write_store.sv
// rtl/db_write_store.sv - endpoint buffer write side, storage array and occupancy tracking
// Optional sticky error flags enabled by defining DB_ERR_FLAGS_EN.
module db_write_store
    import db_pkg::*;
(
    input  logic     clk,
    input  logic     n_rst,
    input  logic     store_tx_data,
    input  db_byte_t tx_data,
    input  logic     store_rx_packet_data,
    input  db_byte_t rx_packet_data,
    input  logic     clear,
    input  logic     flush,
    input  logic     read_en,
    input  db_ptr_t  read_ptr,
    output db_ptr_t  buffer_occupancy,
    output db_ptr_t  write_ptr,
    output db_byte_t rd_data,
    output logic     buf_full,
    output logic     buf_empty,
    output logic     overflow_err,
    output logic     wr_conflict_err
);

    db_byte_t mem_q [DEPTH];
    db_ptr_t  write_ptr_q;
    db_ptr_t  write_ptr_d;
    db_ptr_t  occ;
    db_byte_t wr_byte;
    logic     reset_buf;
    logic     store_any;
    logic     full;
    logic     wr_accept;
    logic     unused_read_ptr_msb;

    assign reset_buf = clear | flush;
    assign store_any = store_tx_data | store_rx_packet_data;
    assign full      = (occ == PTR_W'(DEPTH));
    assign wr_accept = store_any && !full && !reset_buf;
    // RX decoder traffic cannot be stalled, so it owns the write port on a collision.
    assign wr_byte   = store_rx_packet_data ? rx_packet_data : tx_data;

    always_comb begin
        write_ptr_d = write_ptr_q;
        if (reset_buf) begin
            write_ptr_d = '0;
        end else if (wr_accept) begin
            write_ptr_d = write_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            write_ptr_q <= '0;
        end else begin
            write_ptr_q <= write_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[write_ptr_q[PTR_W-2:0]] <= wr_byte;
        end
    end

    db_occ_counter u_occ (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (reset_buf),
        .inc_i (wr_accept),
        .dec_i (read_en && !reset_buf),
        .occ_o (occ)
    );

`ifdef DB_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic conflict_q;
    logic conflict_d;

    always_comb begin
        overflow_d = overflow_q;
        conflict_d = conflict_q;
        if (reset_buf) begin
            overflow_d = 1'b0;
            conflict_d = 1'b0;
        end else begin
            if (store_any && full) begin
                overflow_d = 1'b1;
            end
            if (store_tx_data && store_rx_packet_data) begin
                conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            conflict_q <= conflict_d;
        end
    end

    assign overflow_err    = overflow_q;
    assign wr_conflict_err = conflict_q;
`else
    assign overflow_err    = 1'b0;
    assign wr_conflict_err = 1'b0;
`endif

    assign unused_read_ptr_msb = read_ptr[PTR_W-1];
    assign rd_data             = mem_q[read_ptr[PTR_W-2:0]];
    assign write_ptr           = write_ptr_q;
    assign buffer_occupancy    = occ;
    assign buf_full            = full;
    assign buf_empty           = (occ == '0);

endmodule
